// File: rtl/cancel_accumulator.sv
// -----------------------------------------------------------------------------
// cancel_accumulator
//
// Read-modify-write controller for the per-client cancelled-order RAM. After
// reset it zero-fills every RAM location, then accepts one cancel event per
// cycle: it reads the client's running total, adds the cancelled amount with
// saturation (or clears the total), writes the result back, and publishes the
// updated total together with a threshold alarm.
//
// Ports
//   clk             sole clock; the RAM read and write ports run on it too
//   rst             synchronous, active-high reset
//   in_valid        cancel event valid
//   in_ready        high when an event can be accepted (RUN state only)
//   in_client       client ID of the event
//   in_amount       cancelled quantity to add
//   in_clear        force the client's total to zero (in_amount ignored)
//   threshold       alarm level, unsigned, quasi-static
//   ram_addr_read   RAM read address (follows in_client while ready)
//   ram_data_read   RAM read data, registered, one-cycle latency
//   ram_addr_write  RAM write address
//   ram_data_write  RAM write data
//   ram_we          RAM write enable
//   out_valid       one-cycle pulse: updated total available
//   out_client      client of the update
//   out_total       new total
//   out_alarm       out_total >= threshold
//   out_sat         the addition saturated
//   init_done       zero-fill complete
// -----------------------------------------------------------------------------
module cancel_accumulator #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_client,
    input  logic [D_WIDTH-1:0] in_amount,
    input  logic               in_clear,
    input  logic [D_WIDTH-1:0] threshold,
    output logic [A_WIDTH-1:0] ram_addr_read,
    input  logic [D_WIDTH-1:0] ram_data_read,
    output logic [A_WIDTH-1:0] ram_addr_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_we,
    output logic               out_valid,
    output logic [A_WIDTH-1:0] out_client,
    output logic [D_WIDTH-1:0] out_total,
    output logic               out_alarm,
    output logic               out_sat,
    output logic               init_done
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(A_MAX - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Unsigned add with saturation; the MSB of the return value is the
    // saturation flag, the remaining bits are the (possibly clamped) sum.
    function automatic logic [D_WIDTH:0] sat_add(
        input logic [D_WIDTH-1:0] base,
        input logic [D_WIDTH-1:0] amount
    );
        logic [D_WIDTH:0] sum;
        sum = {1'b0, base} + {1'b0, amount};
        if (sum[D_WIDTH]) begin
            return {1'b1, {D_WIDTH{1'b1}}};
        end
        return sum;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [A_WIDTH-1:0] r_sweep_cnt;
    logic               w_init_we;
    logic               w_run;
    logic               w_accept;

    // S1: event registered at the accept edge
    logic               r_vld_p1;
    logic [A_WIDTH-1:0] r_client_p1;
    logic [D_WIDTH-1:0] r_amount_p1;
    logic               r_clear_p1;

    logic [D_WIDTH-1:0] w_base_p1;
    logic [D_WIDTH:0]   w_add_p1;
    logic [D_WIDTH-1:0] w_result_p1;
    logic               w_sat_p1;

    // W: forward register, a copy of what was written to the RAM last cycle
    logic               r_fwd_vld_p2;
    logic [A_WIDTH-1:0] r_fwd_client_p2;
    logic [D_WIDTH-1:0] r_fwd_data_p2;

    // Output stage
    logic               r_out_valid_p2;
    logic [A_WIDTH-1:0] r_out_client_p2;
    logic [D_WIDTH-1:0] r_out_total_p2;
    logic               r_out_alarm_p2;
    logic               r_out_sat_p2;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_sweep_cnt <= r_sweep_cnt + A_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_we   = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we = 1'b1;
                if (r_sweep_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // While rst is held every control output sits at its idle value, so an
    // event sitting in S1 at the reset edge never reaches the RAM.
    assign in_ready      = w_run & ~rst;
    assign init_done     = w_run & ~rst;
    assign w_accept      = in_valid & in_ready;
    assign ram_addr_read = in_ready ? in_client : '0;

    // ---------------- stage p1: accept -> S1 ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_client_p1 <= in_client;
            r_amount_p1 <= in_amount;
            r_clear_p1  <= in_clear;
        end
    end

    // The RAM returns old data when read and written at the same edge, so a
    // same-client event on the very next cycle takes its base from W.
    assign w_base_p1 = (r_fwd_vld_p2 && (r_fwd_client_p2 == r_client_p1))
                       ? r_fwd_data_p2 : ram_data_read;

    assign w_add_p1    = sat_add(w_base_p1, r_amount_p1);
    assign w_result_p1 = r_clear_p1 ? '0   : w_add_p1[D_WIDTH-1:0];
    assign w_sat_p1    = r_clear_p1 ? 1'b0 : w_add_p1[D_WIDTH];

    always_comb begin
        ram_we         = 1'b0;
        ram_addr_write = '0;
        ram_data_write = '0;
        if (!rst) begin
            if (w_init_we) begin
                ram_we         = 1'b1;
                ram_addr_write = r_sweep_cnt;
            end else if (r_vld_p1) begin
                ram_we         = 1'b1;
                ram_addr_write = r_client_p1;
                ram_data_write = w_result_p1;
            end
        end
    end

    // ---------------- stage p2: S1 -> W / outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_vld_p2 <= 1'b0;
        end else begin
            r_fwd_vld_p2 <= r_vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        r_fwd_client_p2 <= r_client_p1;
        r_fwd_data_p2   <= w_result_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_p2  <= 1'b0;
            r_out_client_p2 <= '0;
            r_out_total_p2  <= '0;
            r_out_alarm_p2  <= 1'b0;
            r_out_sat_p2    <= 1'b0;
        end else begin
            r_out_valid_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_out_client_p2 <= r_client_p1;
                r_out_total_p2  <= w_result_p1;
                r_out_alarm_p2  <= (w_result_p1 >= threshold);
                r_out_sat_p2    <= w_sat_p1;
            end
        end
    end

    assign out_valid  = r_out_valid_p2;
    assign out_client = r_out_client_p2;
    assign out_total  = r_out_total_p2;
    assign out_alarm  = r_out_alarm_p2;
    assign out_sat    = r_out_sat_p2;

endmodule

// File: tb/tb_cancel_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cancel_accumulator
//
// Bench for cancel_accumulator. A dual-port RAM model (registered read,
// read-during-write returns old data) is attached to the RAM ports. A
// reference model keeps each client's total as a plain array, updated at the
// moment an event is accepted, and predicts every output pulse two cycles
// later. Directed scenarios add literal checks of the logged results.
// -----------------------------------------------------------------------------
module tb_cancel_accumulator;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int AM = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_client;
    logic [DW-1:0] in_amount;
    logic          in_clear;
    logic [DW-1:0] threshold;
    logic [AW-1:0] ram_addr_read;
    logic [DW-1:0] ram_data_read;
    logic [AW-1:0] ram_addr_write;
    logic [DW-1:0] ram_data_write;
    logic          ram_we;
    logic          out_valid;
    logic [AW-1:0] out_client;
    logic [DW-1:0] out_total;
    logic          out_alarm;
    logic          out_sat;
    logic          init_done;

    always #5 clk = ~clk;

    cancel_accumulator #(
        .D_WIDTH(DW),
        .A_WIDTH(AW),
        .A_MAX  (AM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_client     (in_client),
        .in_amount     (in_amount),
        .in_clear      (in_clear),
        .threshold     (threshold),
        .ram_addr_read (ram_addr_read),
        .ram_data_read (ram_data_read),
        .ram_addr_write(ram_addr_write),
        .ram_data_write(ram_data_write),
        .ram_we        (ram_we),
        .out_valid     (out_valid),
        .out_client    (out_client),
        .out_total     (out_total),
        .out_alarm     (out_alarm),
        .out_sat       (out_sat),
        .init_done     (init_done)
    );

    // RAM model; starts filled with garbage so the zero-fill is visible
    logic [DW-1:0] mem [AM];
    logic          mem_filled = 1'b0;

    always @(posedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < AM; i++) mem[i] <= 32'hA5A5_0000 + DW'(i);
            mem_filled <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr_write] <= ram_data_write;
        end
        ram_data_read <= mem[ram_addr_read];
    end

    typedef struct {
        int            due;
        logic [AW-1:0] client;
        logic [DW-1:0] total;
        logic          alarm;
        logic          sat;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] m_tot [AM];
    int            n_cmp   = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    bit            started = 0;

    logic [DW-1:0] log_tot[$];
    logic          log_alarm[$];
    logic          log_sat[$];
    int            log_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare against the model, then capture what the next edge will accept.
    always @(negedge clk) begin : cmp_proc
        bit            due;
        exp_t          e;
        exp_t          ne;
        logic [DW:0]   s;
        cyc++;
        if (started) begin
            due = (expq.size() > 0) && (expq[0].due == cyc);
            check("out_valid", out_valid, due);
            if (out_valid) begin
                log_tot.push_back(out_total);
                log_alarm.push_back(out_alarm);
                log_sat.push_back(out_sat);
                log_cyc.push_back(cyc);
            end
            if (due) begin
                e = expq.pop_front();
                if (out_valid) begin
                    check("out_client", out_client, e.client);
                    check("out_total",  out_total,  e.total);
                    check("out_alarm",  out_alarm,  e.alarm);
                    check("out_sat",    out_sat,    e.sat);
                end
            end
            while (expq.size() > 0 && expq[0].due <= cyc) void'(expq.pop_front());

            if (rst) begin
                expq.delete();
                for (int i = 0; i < AM; i++) m_tot[i] = '0;
            end else if (in_valid && in_ready) begin
                ne.due    = cyc + 2;
                ne.client = in_client;
                if (in_clear) begin
                    ne.total = '0;
                    ne.sat   = 1'b0;
                end else begin
                    s = {1'b0, m_tot[in_client]} + {1'b0, in_amount};
                    ne.sat   = s[DW];
                    ne.total = s[DW] ? {DW{1'b1}} : s[DW-1:0];
                end
                ne.alarm = (ne.total >= threshold);
                m_tot[in_client] = ne.total;
                expq.push_back(ne);
            end
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] c, input logic [DW-1:0] a,
                        input logic clr);
        in_valid  = v;
        in_client = c;
        in_amount = a;
        in_clear  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic clear_log();
        log_tot.delete();
        log_alarm.delete();
        log_sat.delete();
        log_cyc.delete();
    endtask

    task automatic check_all_zero(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < AM; i++) if (mem[i] != '0) nz++;
        check(name, nz, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_client = '0;
        in_amount = '0;
        in_clear  = 1'b0;
        threshold = 32'd1000;
        repeat (2) @(posedge clk);
        #1;
        started = 1;

        // reset state
        @(negedge clk);
        check("rst_in_ready",   in_ready,       0);
        check("rst_ram_we",     ram_we,         0);
        check("rst_out_valid",  out_valid,      0);
        check("rst_out_alarm",  out_alarm,      0);
        check("rst_out_sat",    out_sat,        0);
        check("rst_init_done",  init_done,      0);
        check("rst_addr_read",  ram_addr_read,  0);
        check("rst_addr_write", ram_addr_write, 0);
        check("rst_data_write", ram_data_write, 0);
        check("rst_out_client", out_client,     0);
        check("rst_out_total",  out_total,      0);

        // zero-fill sweep; an event offered during INIT must be ignored
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_client = 5'd1;
        in_amount = 32'd5;
        for (int i = 0; i < AM; i++) begin
            @(negedge clk);
            check("init_we",       ram_we,         1);
            check("init_addr",     ram_addr_write, i);
            check("init_data",     ram_data_write, 0);
            check("init_ready",    in_ready,       0);
            check("init_done_low", init_done,      0);
            if (i == 20) in_valid = 1'b0;
        end
        @(negedge clk);
        check("run_ready",     in_ready,  1);
        check("run_init_done", init_done, 1);
        check("run_we_idle",   ram_we,    0);
        check_all_zero("init_mem_zero");
        @(posedge clk);
        #1;

        // client 3: +100, gap of 2, +50
        clear_log();
        step(1'b1, 5'd3, 32'd100, 1'b0);
        idle(2);
        step(1'b1, 5'd3, 32'd50, 1'b0);
        idle(3);
        check("a_count",  log_tot.size(), 2);
        check("a_tot0",   log_tot[0], 100);
        check("a_tot1",   log_tot[1], 150);
        check("a_spacing", log_cyc[1] - log_cyc[0], 3);
        check("a_ram3",   mem[3], 150);
        check("a_ram1",   mem[1], 0);

        // client 7 back to back: forwarding path
        clear_log();
        step(1'b1, 5'd7, 32'd10, 1'b0);
        step(1'b1, 5'd7, 32'd20, 1'b0);
        step(1'b1, 5'd7, 32'd30, 1'b0);
        idle(3);
        check("b_count", log_tot.size(), 3);
        check("b_tot0",  log_tot[0], 10);
        check("b_tot1",  log_tot[1], 30);
        check("b_tot2",  log_tot[2], 60);
        check("b_consec", log_cyc[2] - log_cyc[0], 2);
        check("b_ram7",  mem[7], 60);

        // client 5: threshold edge, then saturation, then clear of saturated
        clear_log();
        step(1'b1, 5'd5, 32'd999, 1'b0);
        step(1'b1, 5'd5, 32'd1, 1'b0);
        step(1'b1, 5'd5, 32'd0, 1'b1);
        step(1'b1, 5'd5, 32'hFFFF_FFF0, 1'b0);
        step(1'b1, 5'd5, 32'h20, 1'b0);
        step(1'b1, 5'd5, 32'd1, 1'b0);
        step(1'b1, 5'd5, 32'd0, 1'b1);
        idle(3);
        check("c_count",  log_tot.size(), 7);
        check("c_tot0",   log_tot[0], 999);
        check("c_alarm0", log_alarm[0], 0);
        check("c_tot1",   log_tot[1], 1000);
        check("c_alarm1", log_alarm[1], 1);
        check("c_tot3",   log_tot[3], 32'hFFFF_FFF0);
        check("c_sat3",   log_sat[3], 0);
        check("c_tot4",   log_tot[4], 32'hFFFF_FFFF);
        check("c_sat4",   log_sat[4], 1);
        check("c_tot5",   log_tot[5], 32'hFFFF_FFFF);
        check("c_sat5",   log_sat[5], 1);
        check("c_tot6",   log_tot[6], 0);
        check("c_sat6",   log_sat[6], 0);
        check("c_ram5",   mem[5], 0);

        // client 9: +40, clear, +5; then a one-cycle gap
        clear_log();
        step(1'b1, 5'd9, 32'd40, 1'b0);
        step(1'b1, 5'd9, 32'd0, 1'b1);
        step(1'b1, 5'd9, 32'd5, 1'b0);
        step(1'b1, 5'd9, 32'd1, 1'b0);
        idle(1);
        step(1'b1, 5'd9, 32'd2, 1'b0);
        idle(3);
        check("d_count", log_tot.size(), 5);
        check("d_tot0",  log_tot[0], 40);
        check("d_tot1",  log_tot[1], 0);
        check("d_sat1",  log_sat[1], 0);
        check("d_tot2",  log_tot[2], 5);
        check("d_tot3",  log_tot[3], 6);
        check("d_tot4",  log_tot[4], 8);
        check("d_ram9",  mem[9], 8);

        // top and bottom addresses interleaved
        clear_log();
        step(1'b1, 5'd31, 32'd7, 1'b0);
        step(1'b1, 5'd0, 32'd3, 1'b0);
        step(1'b1, 5'd31, 32'd1, 1'b0);
        idle(3);
        check("w_tot2",  log_tot[2], 8);
        check("w_ram31", mem[31], 8);
        check("w_ram0",  mem[0], 3);

        // reset the cycle after accepting client 2 +77
        clear_log();
        step(1'b1, 5'd2, 32'd77, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("e_we_in_rst", ram_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(34);
        check("e_no_out",     log_tot.size(), 0);
        check("e_ram2",       mem[2], 0);
        check("e_init_done",  init_done, 1);
        check_all_zero("e_mem_zero");
        step(1'b1, 5'd3, 32'd11, 1'b0);
        idle(3);
        check("e_after_tot", log_tot.size() > 0 ? log_tot[0] : 32'hDEAD_BEEF, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cancel_accumulator.md
# cancel_accumulator

Read-modify-write controller that drives the per-client cancelled-order RAM: it accepts cancel events (client ID, amount), reads the client's running total, adds the amount with saturation, and writes the result back. It sits between the order-event decoder and the dual-port RAM, owning both its read port and its write port. It also publishes each updated total with a threshold alarm for the risk logic. After reset it zero-fills the RAM before accepting events.

## Interface
- D_WIDTH, 32, total/amount width; equals RAM data width
- A_WIDTH, 5, client ID width; equals RAM address width
- A_MAX, 32, number of clients (2^A_WIDTH)

- clk  in  1  sole clock; also drives RAM clk_read and clk_write
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  cancel event valid
- in_ready  out  1  block can accept an event
- in_client  in  A_WIDTH  client ID
- in_amount  in  D_WIDTH  cancelled quantity to add
- in_clear  in  1  when set, sets the client's total to 0; in_amount is ignored
- threshold  in  D_WIDTH  alarm level; quasi-static
- ram_addr_read  out  A_WIDTH  to RAM address_read
- ram_data_read  in  D_WIDTH  from RAM data_read; registered, 1-cycle latency
- ram_addr_write  out  A_WIDTH  to RAM address_write
- ram_data_write  out  D_WIDTH  to RAM data_write
- ram_we  out  1  to RAM write_enable
- out_valid  out  1  one-cycle pulse: updated total is available
- out_client  out  A_WIDTH  client of the update
- out_total  out  D_WIDTH  new total
- out_alarm  out  1  out_total >= threshold
- out_sat  out  1  the addition saturated
- init_done  out  1  zero-fill is complete

## Operation
- FSM states: INIT and RUN. rst forces INIT with sweep counter = 0.
- INIT:
  - ram_we=1, ram_addr_write=counter, ram_data_write=0, in_ready=0.
  - The counter increments each cycle. After address A_MAX-1 is written, the FSM moves to RUN.
  - INIT lasts exactly A_MAX cycles.
- RUN:
  - in_ready=1 every cycle, giving full throughput of one event per cycle.
  - Accept occurs when in_valid and in_ready are both high at the clock edge.
  - ram_addr_read = in_client combinationally, so the RAM captures the address at the accept edge.
- Stage S1 (registered at accept): holds valid, client, amount, and clear.
  - base = ram_data_read, unless forward register W is valid and W.client == S1.client; then base = W.data.
  - sum = base + amount, computed at D_WIDTH+1 bits. If the carry is set, the result saturates to all ones and sat=1.
  - If clear is set: result = 0 and sat = 0.
  - While S1 is valid: ram_we=1, ram_addr_write=S1.client, ram_data_write=result. All three are combinational from S1.
- W register: loads {S1.valid, S1.client, result} every cycle. It covers the RAM's read-during-write-returns-old-data behaviour for back-to-back events to the same client.
- Output registers load at the same edge as the RAM write:
  - out_valid = S1.valid
  - out_total = result
  - out_alarm = (result >= threshold), unsigned compare
  - out_sat = sat
- There is no backpressure from the output side.

## Timing
- The accept edge ends cycle C.
  - S1 is valid in C+1.
  - The RAM write commits at the end of C+1.
  - out_* are valid in C+2.
  - Latency is 2 cycles.
- Reset values:
  - in_ready, ram_we, out_valid, out_alarm, out_sat, init_done: 0
  - ram_addr_read, ram_addr_write, ram_data_write, out_client, out_total: 0
  - S1.valid = 0, W.valid = 0
- In INIT, ram_we=1 from the first cycle after rst deasserts.
- init_done rises on the first RUN cycle, together with in_ready, and stays high until rst.
- Same-client events on consecutive cycles: the second event uses W.data (forwarded), not the RAM data.
- Same-client events with a gap of 1 or more cycles: the RAM data is already current; no forwarding.
- Wrap-around: address A_MAX-1 is handled like any other address. The INIT counter does not wrap back into RUN.
- Reset mid-operation: S1, W and output valids clear at the reset edge, and INIT restarts at address 0. In-flight events are dropped and their writes are not committed.
- Events presented during INIT are not accepted (in_ready=0).

## Test plan
- Reset, then idle → ram_we=1 for exactly 32 cycles writing 0 to addresses 0..31; init_done and in_ready go high on cycle 33.
- Client 3 +100, then 2 idle cycles, then client 3 +50 → out_total=100, then 150; out_valid pulses 2 cycles after each accept; RAM[3]=150.
- Back-to-back client 7 +10, +20, +30 on consecutive cycles → out_total=10, 30, 60 on consecutive cycles (forwarding path exercised).
- threshold=1000; client 5 +999 → alarm=0; then +1 → total=1000, alarm=1. Client 5 set to 0xFFFFFFF0, then +0x20 → out_total=0xFFFFFFFF, out_sat=1.
- Client 9 +40, then in_clear for client 9, then +5 → totals 40, 0, 5; the clear event shows out_sat=0.
- rst asserted the cycle after an accept for client 2 +77 → no out_valid and no write to address 2; INIT restarts, and after INIT RAM[2]=0.
